// File: rtl/tinymips_pkg.sv
// Shared state encoding and run-control constants for the tiny boot controller.
package tinymips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DONE
    } state_t;

    // A cycle limit of this value means the run never times out.
    localparam int NO_LIMIT = 0;

    // The CPU halts by fetching one word past the end of the loaded program.
    localparam int HALT_PAST_END = 1;

endpackage

// File: rtl/tiny_boot_ctrl_if.sv
// Loader handshake and loader-side RAM write port of the boot controller.
interface tiny_boot_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ram_wrEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              mux_sel;

    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, ram_wrEn, ram_addr, ram_data, mux_sel
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, ram_wrEn, ram_addr, ram_data, mux_sel
    );
endinterface

// File: rtl/tiny_boot_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tiny_boot_ctrl.sv
// Boot controller: streams a program into RAM, then runs the CPU until it
// reaches the halt address, hits the cycle limit, or is cleared.
module tiny_boot_ctrl
    import tinymips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int CYC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    tiny_boot_ctrl_if.slave   bus,
    input  logic              start,
    input  logic              clear,
    input  logic [CYC_W-1:0]  cycle_limit,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_rst,
    output logic [ADDR_W:0]   word_count,
    output logic [CYC_W-1:0]  cycles,
    output logic              halted,
    output logic              timeout
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CYC_W-1:0]  UNLIMITED = CYC_W'(NO_LIMIT);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              handshake;
    logic              go;
    logic              halt_hit;
    logic              limit_hit;
    logic [CYC_W:0]    next_count;

    assign bus.ld_ready = (state == IDLE) && !rst;
    assign handshake    = bus.ld_valid && bus.ld_ready;
    assign go           = start && !clear && ((state == ARMED) || (state == DONE));

    // Compared one bit wider so a saturated count can never alias a limit.
    assign next_count = {1'b0, cycles} + (CYC_W+1)'(1);
    assign halt_hit   = ({1'b0, cpu_addr} == word_count);
    assign limit_hit  = (cycle_limit != UNLIMITED) && (next_count == {1'b0, cycle_limit});

    sat_counter #(
        .WIDTH (CYC_W)
    ) u_cycles (
        .clk (clk),
        .rst (rst),
        .clr (go),
        .en  ((state == RUN) && !clear),
        .q   (cycles)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            word_count   <= '0;
            halted       <= 1'b0;
            timeout      <= 1'b0;
            bus.ram_wrEn <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_data <= '0;
            bus.mux_sel  <= 1'b1;
            cpu_rst      <= 1'b1;
        end else begin
            bus.ram_wrEn <= 1'b0;
            if (clear) begin
                state       <= IDLE;
                ptr         <= '0;
                word_count  <= '0;
                bus.mux_sel <= 1'b1;
                cpu_rst     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (handshake) begin
                            bus.ram_wrEn <= 1'b1;
                            bus.ram_addr <= ptr;
                            bus.ram_data <= bus.ld_data;
                            ptr          <= ptr + ADDR_W'(1);
                            if (bus.ld_last || (ptr == LAST_ADDR)) begin
                                word_count <= {1'b0, ptr} + (ADDR_W+1)'(HALT_PAST_END);
                                state      <= ARMED;
                            end
                        end
                    end
                    ARMED, DONE: begin
                        if (start) begin
                            state       <= RUN;
                            halted      <= 1'b0;
                            timeout     <= 1'b0;
                            bus.mux_sel <= 1'b0;
                            cpu_rst     <= 1'b0;
                        end
                    end
                    RUN: begin
                        // Halt takes priority when both end conditions coincide.
                        if (halt_hit) begin
                            state       <= DONE;
                            halted      <= 1'b1;
                            bus.mux_sel <= 1'b1;
                            cpu_rst     <= 1'b1;
                        end else if (limit_hit) begin
                            state       <= DONE;
                            timeout     <= 1'b1;
                            bus.mux_sel <= 1'b1;
                            cpu_rst     <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tiny_boot_ctrl.sv
// Directed bench: RAM writes go through a scoreboard queue, status is checked per step.
module tb_tiny_boot_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int CYC_W  = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic              clear;
    logic [CYC_W-1:0]  cycle_limit;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rst;
    logic [ADDR_W:0]   word_count;
    logic [CYC_W-1:0]  cycles;
    logic              halted;
    logic              timeout;

    tiny_boot_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    tiny_boot_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CYC_W  (CYC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .start       (start),
        .clear       (clear),
        .cycle_limit (cycle_limit),
        .cpu_addr    (cpu_addr),
        .cpu_rst     (cpu_rst),
        .word_count  (word_count),
        .cycles      (cycles),
        .halted      (halted),
        .timeout     (timeout)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] exp_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every RAM write the DUT issues must match the next expected one.
    always @(negedge clk) begin
        if (bus.ram_wrEn === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL ram_write_unexpected: got addr %0h data %0h, required no write",
                         bus.ram_addr, bus.ram_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({bus.ram_addr, bus.ram_data} !== exp_w) begin
                    n_err++;
                    $display("FAIL ram_write: got addr %0h data %0h, required addr %0h data %0h",
                             bus.ram_addr, bus.ram_data,
                             exp_w[ADDR_W+DATA_W-1:DATA_W], exp_w[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [DATA_W-1:0] d, input logic last,
                             input logic [ADDR_W-1:0] a);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        exp_q.push_back({a, d});
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        clear        = 1'b0;
        cycle_limit  = '0;
        cpu_addr     = '0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        tick();
        tick();

        check("rst_ld_ready",   32'(bus.ld_ready), 32'd0);
        check("rst_cpu_rst",    32'(cpu_rst),      32'd1);
        check("rst_mux_sel",    32'(bus.mux_sel),  32'd1);
        check("rst_word_count", 32'(word_count),   32'd0);
        check("rst_cycles",     32'(cycles),       32'd0);
        check("rst_halted",     32'(halted),       32'd0);
        check("rst_timeout",    32'(timeout),      32'd0);
        check("rst_ram_wrEn",   32'(bus.ram_wrEn), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_ld_ready", 32'(bus.ld_ready), 32'd1);

        // Six-word program, halt at address 6
        for (int i = 0; i < 6; i++) load_word(16'hA000 + 16'(i), (i == 5), 8'(i));
        check("load6_word_count", 32'(word_count),   32'd6);
        check("armed_ld_ready",   32'(bus.ld_ready), 32'd0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'hDEAD;
        tick();
        tick();
        bus.ld_valid = 1'b0;
        check("armed_ignore_wc", 32'(word_count), 32'd6);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_cpu_rst", 32'(cpu_rst),     32'd0);
        check("run_mux_sel", 32'(bus.mux_sel), 32'd0);
        check("run_cycles0", 32'(cycles),      32'd0);
        for (int k = 0; k < 6; k++) begin
            cpu_addr = 8'(k);
            tick();
        end
        check("pre_halt_cycles",  32'(cycles),  32'd6);
        check("pre_halt_cpu_rst", 32'(cpu_rst), 32'd0);
        cpu_addr = 8'd6;
        tick();
        check("halt_halted",  32'(halted),      32'd1);
        check("halt_timeout", 32'(timeout),     32'd0);
        check("halt_cycles",  32'(cycles),      32'd7);
        check("halt_cpu_rst", 32'(cpu_rst),     32'd1);
        check("halt_mux_sel", 32'(bus.mux_sel), 32'd1);
        cpu_addr = 8'd0;
        tick();
        tick();
        check("done_hold_cycles", 32'(cycles), 32'd7);
        check("done_hold_halted", 32'(halted), 32'd1);

        // Rerun from DONE with a 20-cycle limit, halt never reached
        cycle_limit = 16'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_halted_clr",  32'(halted),  32'd0);
        check("rerun_timeout_clr", 32'(timeout), 32'd0);
        check("rerun_cycles_clr",  32'(cycles),  32'd0);
        repeat (19) tick();
        check("limit_pre_cycles",  32'(cycles),  32'd19);
        check("limit_pre_cpu_rst", 32'(cpu_rst), 32'd0);
        tick();
        check("limit_cycles",  32'(cycles),  32'd20);
        check("limit_timeout", 32'(timeout), 32'd1);
        check("limit_halted",  32'(halted),  32'd0);
        check("limit_cpu_rst", 32'(cpu_rst), 32'd1);

        // Halt and limit on the same cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        check("both_timeout_clr", 32'(timeout), 32'd0);
        repeat (19) tick();
        cpu_addr = 8'd6;
        tick();
        cpu_addr = 8'd0;
        check("both_halted",  32'(halted),  32'd1);
        check("both_timeout", 32'(timeout), 32'd0);
        check("both_cycles",  32'(cycles),  32'd20);

        // clear and start together: clear wins
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("clear_word_count",  32'(word_count),   32'd0);
        check("clear_ld_ready",    32'(bus.ld_ready), 32'd1);
        check("clear_cpu_rst",     32'(cpu_rst),      32'd1);
        check("clear_keep_cycles", 32'(cycles),       32'd20);
        check("clear_keep_halted", 32'(halted),       32'd1);

        // Full-depth load without ld_last
        for (int i = 0; i < 256; i++) load_word(16'(i * 3) ^ 16'h5A5A, 1'b0, 8'(i));
        check("full_word_count", 32'(word_count),   32'd256);
        check("full_ld_ready",   32'(bus.ld_ready), 32'd0);
        bus.ld_valid = 1'b1;
        repeat (3) tick();
        bus.ld_valid = 1'b0;

        // Halt address unreachable with a full program: sweep every address
        cycle_limit = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 256; k++) begin
            cpu_addr = 8'(k);
            tick();
        end
        check("full_run_cpu_rst", 32'(cpu_rst), 32'd0);
        check("full_run_cycles",  32'(cycles),  32'd256);
        check("full_run_halted",  32'(halted),  32'd0);

        // Reset in the middle of a run
        rst = 1'b1;
        tick();
        check("midrst_cpu_rst",    32'(cpu_rst),     32'd1);
        check("midrst_mux_sel",    32'(bus.mux_sel), 32'd1);
        check("midrst_cycles",     32'(cycles),      32'd0);
        check("midrst_word_count", 32'(word_count),  32'd0);
        check("midrst_timeout",    32'(timeout),     32'd0);
        rst = 1'b0;
        cpu_addr = 8'd0;
        tick();
        check("midrst_idle_ld_ready", 32'(bus.ld_ready), 32'd1);

        // Pointer restarts at 0 after reset; single-word program
        load_word(16'h1234, 1'b1, 8'd0);
        check("single_word_count", 32'(word_count), 32'd1);
        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
